// File: rtl/modaddsub_pkg.sv
// Shared types and constants for the multi-operand modular add/subtract accumulator.
package modaddsub_pkg;

  localparam int unsigned DefIdw  = 256;
  localparam int unsigned DefNops = 3;

  // Per-operand select bit encoding in the sub mask.
  localparam logic MaskAdd = 1'b0;
  localparam logic MaskSub = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } state_e;

endpackage

// File: rtl/modaddsub_step.sv
// One modular add/subtract stage: acc +/- op with a single correction by p.
module modaddsub_step #(
  parameter int unsigned IDW = 256
) (
  input  logic [IDW-1:0] acc_i,
  input  logic [IDW-1:0] op_i,
  input  logic [IDW-1:0] p_i,
  input  logic           sub_i,
  output logic [IDW-1:0] nxt_o
);

  logic [IDW:0]   sum;
  logic [IDW:0]   diff;
  logic [IDW-1:0] sum_red;

  assign sum     = {1'b0, acc_i} + {1'b0, op_i};
  assign diff    = {1'b0, acc_i} - {1'b0, op_i};
  assign sum_red = sum[IDW-1:0] - p_i;

  always_comb begin
    nxt_o = sum[IDW-1:0];
    if (sub_i) begin
      // diff[IDW] is the borrow out of the subtraction.
      nxt_o = diff[IDW] ? (diff[IDW-1:0] + p_i) : diff[IDW-1:0];
    end else if (sum >= {1'b0, p_i}) begin
      nxt_o = sum_red;
    end
  end

endmodule

// File: rtl/modaddsub_multi.sv
// Iterative NOPS-operand modular accumulator with valid/ready handshakes.
// Define MODADDSUB_DUAL_EN to process two operands per ACC cycle.
module modaddsub_multi
  import modaddsub_pkg::*;
#(
  parameter int unsigned IDW  = DefIdw,
  parameter int unsigned NOPS = DefNops,
  parameter int unsigned CNTW = $clog2(NOPS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [NOPS*IDW-1:0] i_ops,
  input  logic [NOPS-1:0]   i_sub_mask,
  input  logic [IDW-1:0]    i_p,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [IDW-1:0]    o_res,
  output logic              o_flag
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] idx_q, idx_d;
  logic [IDW-1:0]  acc_q, acc_d;
  logic [IDW-1:0]  res_q, res_d;
  logic            flag_q, flag_d;

  logic [IDW-1:0]  ops_q [NOPS];
  logic [NOPS-1:0] mask_q;
  logic [IDW-1:0]  p_q;
  logic            flag_pend_q;

  logic            accept;
  logic            in_flag;
  logic [IDW-1:0]  nxt0;
  logic [IDW-1:0]  acc_step;
  logic [CNTW-1:0] idx_step;
  logic            last;

  assign accept      = (state_q == StIdle) && i_in_valid;
  assign o_in_ready  = (state_q == StIdle) && i_rstn;
  assign o_out_valid = (state_q == StDone);
  assign o_res       = res_q;
  assign o_flag      = flag_q;

  always_comb begin
    in_flag = (i_p == '0);
    for (int k = 0; k < int'(NOPS); k++) begin
      if (i_ops[k*IDW +: IDW] >= i_p) in_flag = 1'b1;
    end
  end

  modaddsub_step #(.IDW(IDW)) u_step0 (
    .acc_i (acc_q),
    .op_i  (ops_q[idx_q]),
    .p_i   (p_q),
    .sub_i (mask_q[idx_q] == MaskSub),
    .nxt_o (nxt0)
  );

`ifdef MODADDSUB_DUAL_EN
  logic [CNTW-1:0] idx1;
  logic            has1;
  logic [IDW-1:0]  op1;
  logic            sub1;
  logic [IDW-1:0]  nxt1;

  assign idx1 = idx_q + CNTW'(1);
  assign has1 = (32'(idx_q) + 32'd1) < NOPS;
  assign op1  = has1 ? ops_q[idx1] : '0;
  assign sub1 = has1 ? (mask_q[idx1] == MaskSub) : 1'b0;

  modaddsub_step #(.IDW(IDW)) u_step1 (
    .acc_i (nxt0),
    .op_i  (op1),
    .p_i   (p_q),
    .sub_i (sub1),
    .nxt_o (nxt1)
  );

  // With an odd count the final cycle carries only one operand.
  assign acc_step = has1 ? nxt1 : nxt0;
  assign idx_step = idx_q + CNTW'(2);
  assign last     = (32'(idx_q) + 32'd2) >= NOPS;
`else
  assign acc_step = nxt0;
  assign idx_step = idx_q + CNTW'(1);
  assign last     = (32'(idx_q) + 32'd1) >= NOPS;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    res_d   = res_q;
    flag_d  = flag_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d = acc_step;
        idx_d = idx_step;
        if (last) begin
          res_d   = (p_q == '0) ? '0 : acc_step;
          flag_d  = flag_pend_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (i_out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < int'(NOPS); k++) ops_q[k] <= '0;
      mask_q      <= '0;
      p_q         <= '0;
      flag_pend_q <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < int'(NOPS); k++) ops_q[k] <= i_ops[k*IDW +: IDW];
      mask_q      <= i_sub_mask;
      p_q         <= i_p;
      flag_pend_q <= in_flag;
    end
  end

endmodule
